// File: rtl/aes_dec_seq_if.sv
// aes_dec_seq_if: block-level handshake between cipher-text source, decryption sequencer and plaintext sink.
// Valid/ready: a transfer occurs on a rising clk edge where valid and ready are both 1; the sender holds data stable while valid=1 and ready=0.
interface aes_dec_seq_if #(
    parameter int KW = 128
);
    logic          in_valid;
    logic          in_ready;
    logic [KW-1:0] ct_in;
    logic [KW-1:0] key_in;
    logic          out_valid;
    logic          out_ready;
    logic [KW-1:0] pt_out;

    modport master (
        output in_valid, ct_in, key_in, out_ready,
        input  in_ready, out_valid, pt_out
    );

    modport slave (
        input  in_valid, ct_in, key_in, out_ready,
        output in_ready, out_valid, pt_out
    );
endinterface

// File: rtl/aes_dec_seq.sv
// aes_dec_seq: iterative AES-128 decryption sequencer driving external key-expansion and inverse-round logic.
// Optional key cache enabled by defining AES_DEC_KEYCACHE_EN (skips key expansion when the key repeats).
module aes_dec_seq #(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    aes_dec_seq_if.slave  io,
    output logic [3:0]    kexp_rc,
    output logic [KW-1:0] kexp_key_prev,
    input  logic [KW-1:0] kexp_key_next,
    output logic [KW-1:0] rnd_state_o,
    output logic [KW-1:0] rnd_key_o,
    output logic          rnd_last,
    input  logic [KW-1:0] rnd_state_i,
    output logic          busy,
    output logic [1:0]    dbg_state
);
    localparam logic [3:0] LAST_RND = 4'(NR);

    // Encoding is visible on dbg_state: 0 IDLE, 1 KEXP, 2 ROUND, 3 DONE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEXP  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    fsm_t          fsm;
    fsm_t          fsm_next;
    logic [3:0]    cnt;
    logic [3:0]    cnt_next;
    logic [3:0]    rk_idx;
    logic [KW-1:0] ct_q;
    logic [KW-1:0] state_q;
    logic [KW-1:0] pt_q;
    logic [KW-1:0] rk [0:NR];

    logic accept;
    logic cache_hit;
    logic kexp_wr;
    logic kexp_last;
    logic round_wr;
    logic round_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm <= IDLE;
            cnt <= 4'd0;
        end else begin
            fsm <= fsm_next;
            cnt <= cnt_next;
        end
    end

    always_comb begin
        fsm_next     = fsm;
        cnt_next     = cnt;
        accept       = 1'b0;
        kexp_wr      = 1'b0;
        kexp_last    = 1'b0;
        round_wr     = 1'b0;
        round_last   = 1'b0;
        rk_idx       = 4'd0;
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        busy         = 1'b1;
        kexp_rc      = 4'd0;
        rnd_last     = 1'b0;
        case (fsm)
            IDLE: begin
                io.in_ready = 1'b1;
                busy        = 1'b0;
                if (io.in_valid) begin
                    accept = 1'b1;
                    if (cache_hit) begin
                        fsm_next = ROUND;
                        cnt_next = LAST_RND;
                    end else begin
                        fsm_next = KEXP;
                        cnt_next = 4'd1;
                    end
                end
            end
            KEXP: begin
                kexp_rc = cnt;
                rk_idx  = cnt - 4'd1;
                kexp_wr = 1'b1;
                if (cnt == LAST_RND) begin
                    kexp_last = 1'b1;
                    fsm_next  = ROUND;
                    cnt_next  = LAST_RND;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            ROUND: begin
                rk_idx   = cnt - 4'd1;
                round_wr = 1'b1;
                rnd_last = (cnt == 4'd1);
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    round_last = 1'b1;
                    fsm_next   = DONE;
                end
            end
            DONE: begin
                io.out_valid = 1'b1;
                if (io.out_ready) begin
                    fsm_next = IDLE;
                end
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    assign kexp_key_prev = (fsm == KEXP)  ? rk[rk_idx] : '0;
    assign rnd_key_o     = (fsm == ROUND) ? rk[rk_idx] : '0;
    assign rnd_state_o   = state_q;
    assign io.pt_out     = pt_q;
    assign dbg_state     = fsm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ct_q    <= '0;
            state_q <= '0;
            pt_q    <= '0;
        end else begin
            if (accept) begin
                ct_q <= io.ct_in;
                if (cache_hit) begin
                    state_q <= io.ct_in ^ rk[NR];
                end
            end
            // The final expanded key doubles as the initial AddRoundKey of decryption.
            if (kexp_last) begin
                state_q <= ct_q ^ kexp_key_next;
            end
            if (round_wr) begin
                state_q <= rnd_state_i;
            end
            if (round_last) begin
                pt_q <= rnd_state_i;
            end
        end
    end

    // Round-key store carries no reset; its contents are only trusted after a full expansion.
    always_ff @(posedge clk) begin
        if (accept && !cache_hit) begin
            rk[0] <= io.key_in;
        end
        if (kexp_wr) begin
            rk[cnt] <= kexp_key_next;
        end
    end

`ifdef AES_DEC_KEYCACHE_EN
    logic [KW-1:0] tag;
    logic          tag_valid;

    // A miss starts overwriting rk[], so the tag is invalid until that expansion completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag       <= '0;
            tag_valid <= 1'b0;
        end else if (accept && !cache_hit) begin
            tag_valid <= 1'b0;
        end else if (kexp_last) begin
            tag       <= rk[0];
            tag_valid <= 1'b1;
        end
    end

    assign cache_hit = tag_valid && (io.key_in == tag);
`else
    assign cache_hit = 1'b0;
`endif

endmodule

// File: tb/tb_aes_dec_seq.sv
// tb_aes_dec_seq: self-checking bench with behavioural key-expansion/inverse-round models and a full AES-128 reference.
// Latency expectations follow AES_DEC_KEYCACHE_EN when it is defined for the build.
module tb_aes_dec_seq;
`ifdef AES_DEC_KEYCACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [3:0]   kexp_rc;
    logic [127:0] kexp_key_prev;
    logic [127:0] kexp_key_next;
    logic [127:0] rnd_state_o;
    logic [127:0] rnd_key_o;
    logic         rnd_last;
    logic [127:0] rnd_state_i;
    logic         busy;
    logic [1:0]   dbg_state;

    aes_dec_seq_if #(.KW(128)) io ();

    aes_dec_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .io            (io),
        .kexp_rc       (kexp_rc),
        .kexp_key_prev (kexp_key_prev),
        .kexp_key_next (kexp_key_next),
        .rnd_state_o   (rnd_state_o),
        .rnd_key_o     (rnd_key_o),
        .rnd_last      (rnd_last),
        .rnd_state_i   (rnd_state_i),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- AES arithmetic ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        if (x == 8'h00) return 8'h00;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return ginv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        for (int k = 0; k < 16; k++)
            o[127-8*k -: 8] = inv ? inv_sbox(s[127-8*k -: 8]) : sbox(s[127-8*k -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        if (inv) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef[(j - r + 4) % 4], s[127-8*(4*c+j) -: 8]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] key_step(input int rc, input logic [127:0] prev);
        logic [7:0]  rcon;
        logic [31:0] t;
        logic [31:0] w0, w1, w2, w3;
        if (rc < 1 || rc > 10) return prev;
        rcon = 8'h01;
        for (int i = 1; i < rc; i++) rcon = xtime(rcon);
        t  = {prev[23:0], prev[31:24]};
        t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
        w0 = prev[127:96] ^ t;
        w1 = prev[95:64] ^ w0;
        w2 = prev[63:32] ^ w1;
        w3 = prev[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [127:0] t;
        t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
        return last ? t : mix_columns(t, 1'b1);
    endfunction

    // Reference model: forward cipher, so a random plaintext round-trips through the DUT.
    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] rk [11];
        logic [127:0] s;
        rk[0] = key;
        for (int i = 1; i <= 10; i++) rk[i] = key_step(i, rk[i-1]);
        s = pt ^ rk[0];
        for (int r = 1; r < 10; r++) s = mix_columns(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ rk[r];
        return shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ rk[10];
    endfunction

    // External combinational datapaths the sequencer drives.
    assign kexp_key_next = key_step(int'(kexp_rc), kexp_key_prev);
    assign rnd_state_i   = inv_round(rnd_state_o, rnd_key_o, rnd_last);

    // ---------------- scoreboard / checking ----------------
    int           n_checks;
    int           n_errors;
    logic [127:0] exp_q [$];
    logic [127:0] m_key;
    bit           m_valid;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_op(input logic [127:0] key, output int elat);
        if (CACHE_EN && m_valid && key == m_key) begin
            elat = 10;
        end else begin
            elat    = 20;
            m_key   = key;
            m_valid = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, io.in_ready, 128'd1);
        check({tag, "_out_valid"}, io.out_valid, 128'd0);
        check({tag, "_busy"}, busy, 128'd0);
        check({tag, "_pt_out"}, io.pt_out, 128'd0);
        check({tag, "_kexp_rc"}, kexp_rc, 128'd0);
        check({tag, "_rnd_last"}, rnd_last, 128'd0);
        check({tag, "_dbg_state"}, dbg_state, 128'd0);
    endtask

    // ---------------- driver ----------------
    logic [3:0]   rc_trace [0:39];
    logic         last_trace [0:39];
    logic [127:0] key_at_last;
    int           last_cnt;

    task automatic run_block(input logic [127:0] ct, input logic [127:0] key, input int ready_delay,
                             output logic [127:0] pt, output int lat);
        int guard;
        pt          = '0;
        lat         = -1;
        last_cnt    = 0;
        key_at_last = '0;
        guard       = 0;
        @(negedge clk);
        while (!io.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        io.in_valid = 1'b1;
        io.ct_in    = ct;
        io.key_in   = key;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (io.out_valid) begin
                lat = j;
                break;
            end
            rc_trace[j]   = kexp_rc;
            last_trace[j] = rnd_last;
            if (rnd_last) begin
                last_cnt++;
                key_at_last = rnd_key_o;
            end
        end
        if (lat >= 0) begin
            repeat (ready_delay) @(negedge clk);
            pt           = io.pt_out;
            io.out_ready = 1'b1;
            @(posedge clk);
            #1;
            io.out_ready = 1'b0;
        end
    endtask

    task automatic check_traces(input string tag, input logic [127:0] key, input int lat);
        int bad_rc;
        int bad_last;
        int exp_rc;
        bad_rc   = 0;
        bad_last = 0;
        for (int j = 0; j < lat && j < 40; j++) begin
            exp_rc = (lat == 20 && j < 10) ? j + 1 : 0;
            if (int'(rc_trace[j]) != exp_rc) bad_rc++;
            if (last_trace[j] != (j == lat - 1)) bad_last++;
        end
        check({tag, "_kexp_rc_seq_errs"}, bad_rc, 128'd0);
        check({tag, "_rnd_last_pos_errs"}, bad_last, 128'd0);
        check({tag, "_rnd_last_count"}, last_cnt, 128'd1);
        check({tag, "_rnd_key_at_last"}, key_at_last, key);
    endtask

    // ---------------- test ----------------
    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [127:0] got;
        logic [127:0] key;
        logic [127:0] pt;
        int           lat;
        int           elat;
        int           ridx;
        int           seen;

        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                    128'h6bc1bee22e409f96e93d7e117393172a};
        vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hf5d3d58503b9699de785895a96fdbaaf,
                    128'hae2d8a571e03ac9c9eb76fac45af8e51};
        vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h43b1cd7f598ece23881b00e3ed030688,
                    128'h30c81c46a35ce411e5fbc1191a0a52ef};
        vecs[4] = vecs[0];

        n_checks     = 0;
        n_errors     = 0;
        m_valid      = 1'b0;
        m_key        = '0;
        rst_n        = 1'b0;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        io.ct_in     = '0;
        io.key_in    = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Known-answer table: FIPS-197 C.1 and SP800-38A ECB blocks sharing one key.
        for (int i = 0; i < 5; i++) begin
            model_op(vecs[i].key, elat);
            run_block(vecs[i].ct, vecs[i].key, 0, got, lat);
            check($sformatf("tbl%0d_pt", i), got, vecs[i].pt);
            check($sformatf("tbl%0d_latency", i), lat, elat);
            check_traces($sformatf("tbl%0d", i), vecs[i].key, lat);
        end

        // Back-to-back with in_valid held high; first result withheld for 5 cycles.
        exp_q.delete();
        for (int b = 0; b < 3; b++) model_op(vecs[b+1].key, elat);
        @(negedge clk);
        fork
            begin : source
                int g;
                io.in_valid = 1'b1;
                for (int b = 0; b < 3; b++) begin
                    io.ct_in  = vecs[b+1].ct;
                    io.key_in = vecs[b+1].key;
                    exp_q.push_back(vecs[b+1].pt);
                    g = 0;
                    while (!io.in_ready && g < 200) begin
                        @(negedge clk);
                        g++;
                    end
                    @(posedge clk);
                    @(negedge clk);
                end
                io.in_valid = 1'b0;
            end
            begin : sink
                int           g2;
                logic [127:0] held;
                logic [127:0] rcv;
                for (int b = 0; b < 3; b++) begin
                    g2 = 0;
                    @(negedge clk);
                    while (!io.out_valid && g2 < 100) begin
                        @(negedge clk);
                        g2++;
                    end
                    if (!io.out_valid) begin
                        check("b2b_out_valid_timeout", io.out_valid, 128'd1);
                        break;
                    end
                    if (b == 0) begin
                        held = io.pt_out;
                        for (int k = 0; k < 5; k++) begin
                            @(negedge clk);
                            check("hold_out_valid", io.out_valid, 128'd1);
                            check("hold_in_ready", io.in_ready, 128'd0);
                            check("hold_pt_stable", io.pt_out, held);
                        end
                    end
                    rcv          = io.pt_out;
                    io.out_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    io.out_ready = 1'b0;
                    if (exp_q.size() == 0) check("b2b_unexpected_output", rcv, 128'd0);
                    else check($sformatf("b2b%0d_pt", b), rcv, exp_q.pop_front());
                end
            end
        join
        io.in_valid = 1'b0;

        // Reset in ROUND r=5: abort, no partial result, key expansion repeats afterwards.
        model_op(vecs[0].key, elat);
        ridx = (elat == 10) ? 5 : 15;
        @(negedge clk);
        io.in_valid = 1'b1;
        io.ct_in    = vecs[0].ct;
        io.key_in   = vecs[0].key;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        repeat (ridx + 1) @(negedge clk);
        check("pre_reset_in_round", dbg_state, 128'd2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        m_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (25) begin
            @(negedge clk);
            if (io.out_valid) seen++;
        end
        check("no_partial_result", seen, 128'd0);
        model_op(vecs[0].key, elat);
        run_block(vecs[0].ct, vecs[0].key, 0, got, lat);
        check("after_reset_pt", got, vecs[0].pt);
        check("after_reset_latency", lat, elat);

        // Random round-trips, sometimes reusing the previous key.
        key = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 0) key = {$urandom, $urandom, $urandom, $urandom};
            pt = {$urandom, $urandom, $urandom, $urandom};
            model_op(key, elat);
            run_block(aes_encrypt(pt, key), key, $urandom_range(0, 3), got, lat);
            check($sformatf("rnd%0d_pt", i), got, pt);
            check($sformatf("rnd%0d_latency", i), lat, elat);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
